// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

    // Accumulator holds both halves plus one carry/borrow bit.
    function automatic int acc_width(input int width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_addsub_unit.sv
// Ripple-carry adder/subtractor from gate primitives; sub=1 computes a - b,
// and cout is then the "no borrow" flag.
module addsub_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic bx_s;
        logic axb_s;
        logic gen_s;
        logic prop_s;
        logic cin_s;
        logic cout_s;

        if (i == 0) begin : g_lsb
            assign cin_s = sub;
        end else begin : g_chain
            assign cin_s = g_bit[i-1].cout_s;
        end

        xor u_bx  (bx_s,   b[i],  sub);
        xor u_axb (axb_s,  a[i],  bx_s);
        xor u_sum (sum[i], axb_s, cin_s);
        and u_gen (gen_s,  a[i],  bx_s);
        and u_prp (prop_s, axb_s, cin_s);
        or  u_co  (cout_s, gen_s, prop_s);
    end

    assign cout = g_bit[WIDTH-1].cout_s;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply / restoring divide controller owning HI/LO.
// Two addsub_unit instances: unit 0 does the per-bit add/subtract, both negate.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             wrhi,
    input  logic             wrlo,
    input  logic [WIDTH-1:0] wrdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               ACC_W     = acc_width(WIDTH);
    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W    = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e             state_r, state_n;
    op_e                op_r, op_n;
    logic [ACC_W-1:0]   acc_r, acc_n;
    logic [WIDTH-1:0]   mcand_r, mcand_n;
    logic [CNT_W-1:0]   cnt_r, cnt_n;
    logic               neg_lo_r, neg_lo_n;
    logic               neg_hi_r, neg_hi_n;
    logic [WIDTH-1:0]   hi_r, hi_n;
    logic [WIDTH-1:0]   lo_r, lo_n;
    logic               done_r, done_n;
    logic               busy_r;

    logic [WIDTH-1:0]   u0_a_s, u0_b_s, u0_sum_s;
    logic               u0_sub_s, u0_cout_s;
    logic [WIDTH-1:0]   u1_a_s, u1_b_s, u1_sum_s;
    logic               u1_sub_s, u1_cout_s;

    logic               div_in_s, div_r_s, sa_s, sb_s, dz_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s;
    logic               nonneg_s;
    logic [WIDTH-1:0]   rem_s;
    logic [2*WIDTH-1:0] res_s;

    addsub_unit #(.WIDTH(WIDTH)) u_addsub0 (
        .a(u0_a_s), .b(u0_b_s), .sub(u0_sub_s), .sum(u0_sum_s), .cout(u0_cout_s)
    );

    addsub_unit #(.WIDTH(WIDTH)) u_addsub1 (
        .a(u1_a_s), .b(u1_b_s), .sub(u1_sub_s), .sum(u1_sum_s), .cout(u1_cout_s)
    );

    // In IDLE unit 1 computes 0 - b, whose carry-out flags a zero divisor.
    assign div_in_s = op[1];
    assign div_r_s  = (op_r == OP_DIVU) || (op_r == OP_DIV);
    assign sa_s     = op[0] & a[WIDTH-1];
    assign sb_s     = op[0] & b[WIDTH-1];
    assign dz_s     = div_in_s & u1_cout_s;
    assign mag_a_s  = (sa_s && !dz_s) ? u0_sum_s : a;
    assign mag_b_s  = sb_s ? u1_sum_s : b;

    // Divide keeps {0, rem, quot}; multiply keeps {carry, P, M} one shift behind.
    assign nonneg_s = acc_r[2*WIDTH-1] | u0_cout_s;
    assign rem_s    = nonneg_s ? u0_sum_s : acc_r[2*WIDTH-2:WIDTH-1];
    assign res_s    = div_r_s ? acc_r[2*WIDTH-1:0] : acc_r[2*WIDTH:1];

    // Next-state, datapath steering and HI/LO update.
    always_comb begin
        state_n  = state_r;
        op_n     = op_r;
        acc_n    = acc_r;
        mcand_n  = mcand_r;
        cnt_n    = cnt_r;
        neg_lo_n = neg_lo_r;
        neg_hi_n = neg_hi_r;
        hi_n     = hi_r;
        lo_n     = lo_r;
        done_n   = 1'b0;
        u0_a_s   = ZERO_W;
        u0_b_s   = ZERO_W;
        u0_sub_s = 1'b0;
        u1_a_s   = ZERO_W;
        u1_b_s   = ZERO_W;
        u1_sub_s = 1'b0;
        case (state_r)
            IDLE: begin
                u0_b_s   = a;
                u0_sub_s = 1'b1;
                u1_b_s   = b;
                u1_sub_s = 1'b1;
                if (wrhi) hi_n = wrdata;
                else      hi_n = hi_r;
                if (wrlo) lo_n = wrdata;
                else      lo_n = lo_r;
                if (start && !cancel) begin
                    op_n    = op_e'(op);
                    cnt_n   = CNT_ZERO;
                    state_n = CALC;
                    if (div_in_s) begin
                        acc_n    = {1'b0, ZERO_W, mag_a_s};
                        mcand_n  = mag_b_s;
                        neg_lo_n = !dz_s & (sa_s ^ sb_s);
                        neg_hi_n = !dz_s & sa_s;
                    end else begin
                        acc_n    = {ZERO_W, mag_b_s, 1'b0};
                        mcand_n  = mag_a_s;
                        neg_lo_n = sa_s ^ sb_s;
                        neg_hi_n = sa_s ^ sb_s;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            CALC: begin
                if (div_r_s) begin
                    u0_a_s   = acc_r[2*WIDTH-2:WIDTH-1];
                    u0_b_s   = mcand_r;
                    u0_sub_s = 1'b1;
                end else begin
                    u0_a_s   = acc_r[2*WIDTH:WIDTH+1];
                    u0_b_s   = acc_r[1] ? mcand_r : ZERO_W;
                    u0_sub_s = 1'b0;
                end
                if (cancel) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_r + CNT_ONE;
                    if (div_r_s) acc_n = {1'b0, rem_s, acc_r[WIDTH-2:0], nonneg_s};
                    else         acc_n = {u0_cout_s, u0_sum_s, acc_r[WIDTH:1]};
                    if (cnt_r == LAST_ITER) state_n = FIX;
                    else                    state_n = CALC;
                end
            end
            FIX: begin
                // High half of a product negation borrows only when the low half is nonzero.
                u0_b_s   = res_s[WIDTH-1:0];
                u0_sub_s = 1'b1;
                u1_a_s   = (!div_r_s && !u0_cout_s) ? ONES_W : ZERO_W;
                u1_b_s   = res_s[2*WIDTH-1:WIDTH];
                u1_sub_s = 1'b1;
                state_n  = IDLE;
                if (cancel) begin
                    done_n = 1'b0;
                end else begin
                    lo_n   = neg_lo_r ? u0_sum_s : res_s[WIDTH-1:0];
                    hi_n   = neg_hi_r ? u1_sum_s : res_s[2*WIDTH-1:WIDTH];
                    done_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            op_r     <= OP_MULTU;
            acc_r    <= {ACC_W{1'b0}};
            mcand_r  <= ZERO_W;
            cnt_r    <= CNT_ZERO;
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
            hi_r     <= ZERO_W;
            lo_r     <= ZERO_W;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_n;
            op_r     <= op_n;
            acc_r    <= acc_n;
            mcand_r  <= mcand_n;
            cnt_r    <= cnt_n;
            neg_lo_r <= neg_lo_n;
            neg_hi_r <= neg_hi_n;
            hi_r     <= hi_n;
            lo_r     <= lo_n;
            done_r   <= done_n;
            busy_r   <= (state_n != IDLE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (WIDTH=32).
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        wrhi;
    logic        wrlo;
    logic [31:0] wrdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .wrhi(wrhi), .wrlo(wrlo), .wrdata(wrdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // cyc counts clock edges since Start was raised (the launch edge is 1).
    task automatic wait_done(input string name, output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, done, cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
        cancel = 1'b0; wrhi = 1'b0; wrlo = 1'b0; wrdata = 32'h0;
        tick(); tick();
        checks += 4;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b required 0", done); end
        if (hi !== 32'h0)  begin failures++; $display("FAIL reset_hi: got %h required 0", hi); end
        if (lo !== 32'h0)  begin failures++; $display("FAIL reset_lo: got %h required 0", lo); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_multu_latency();
        int cyc;
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL multu_busy_rise: got %b required 1", busy); end
        wait_done("multu", cyc);
        checks += 4;
        if (cyc != 34)            begin failures++; $display("FAIL multu_latency: got %0d required 34", cyc); end
        if (busy !== 1'b0)        begin failures++; $display("FAIL multu_busy_fall: got %b required 0", busy); end
        if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi: got %h required fffffffe", hi); end
        if (lo !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo: got %h required 00000001", lo); end
        tick();
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL multu_done_pulse: got %b required 0", done); end
    endtask

    task automatic test_signed();
        logic [1:0]  v_op [4];
        logic [31:0] v_a  [4];
        logic [31:0] v_b  [4];
        logic [31:0] v_hi [4];
        logic [31:0] v_lo [4];
        int cyc;
        v_op[0] = 2'b01; v_a[0] = 32'hFFFF_FFFD; v_b[0] = 32'd5;         v_hi[0] = 32'hFFFF_FFFF; v_lo[0] = 32'hFFFF_FFF1;
        v_op[1] = 2'b11; v_a[1] = 32'hFFFF_FFF9; v_b[1] = 32'd2;         v_hi[1] = 32'hFFFF_FFFF; v_lo[1] = 32'hFFFF_FFFD;
        v_op[2] = 2'b11; v_a[2] = 32'd7;         v_b[2] = 32'hFFFF_FFFE; v_hi[2] = 32'd1;         v_lo[2] = 32'hFFFF_FFFD;
        v_op[3] = 2'b10; v_a[3] = 32'd100;       v_b[3] = 32'd7;         v_hi[3] = 32'd2;         v_lo[3] = 32'd14;
        for (int i = 0; i < 4; i++) begin
            launch(v_op[i], v_a[i], v_b[i]);
            wait_done("signed", cyc);
            checks += 2;
            if (hi !== v_hi[i]) begin failures++; $display("FAIL signed_hi[%0d]: got %h required %h", i, hi, v_hi[i]); end
            if (lo !== v_lo[i]) begin failures++; $display("FAIL signed_lo[%0d]: got %h required %h", i, lo, v_lo[i]); end
            tick();
        end
    endtask

    task automatic test_div_edges();
        logic [1:0]  v_op [3];
        logic [31:0] v_a  [3];
        logic [31:0] v_b  [3];
        logic [31:0] v_hi [3];
        logic [31:0] v_lo [3];
        int cyc;
        v_op[0] = 2'b10; v_a[0] = 32'h0000_0064; v_b[0] = 32'h0;         v_hi[0] = 32'h0000_0064; v_lo[0] = 32'hFFFF_FFFF;
        v_op[1] = 2'b11; v_a[1] = 32'h8000_0000; v_b[1] = 32'hFFFF_FFFF; v_hi[1] = 32'h0;         v_lo[1] = 32'h8000_0000;
        v_op[2] = 2'b11; v_a[2] = 32'hFFFF_FF9C; v_b[2] = 32'h0;         v_hi[2] = 32'hFFFF_FF9C; v_lo[2] = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            launch(v_op[i], v_a[i], v_b[i]);
            wait_done("divedge", cyc);
            checks += 3;
            if (cyc != 34)      begin failures++; $display("FAIL divedge_latency[%0d]: got %0d required 34", i, cyc); end
            if (hi !== v_hi[i]) begin failures++; $display("FAIL divedge_hi[%0d]: got %h required %h", i, hi, v_hi[i]); end
            if (lo !== v_lo[i]) begin failures++; $display("FAIL divedge_lo[%0d]: got %h required %h", i, lo, v_lo[i]); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        launch(2'b00, 32'd3, 32'd4);
        for (int i = 0; i < 8; i++) tick();
        op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ignored", cyc);
        checks += 2;
        if (lo !== 32'd12) begin failures++; $display("FAIL ignored_lo: got %h required 0000000c", lo); end
        if (hi !== 32'd0)  begin failures++; $display("FAIL ignored_hi: got %h required 0", hi); end
        // Start raised while Done is high must be accepted.
        launch(2'b00, 32'd5, 32'd5);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy: got %b required 1", busy); end
        tick();
        wrlo = 1'b1; wrdata = 32'h0000_DEAD;
        tick();
        wrlo = 1'b0;
        checks++;
        if (lo !== 32'd12) begin failures++; $display("FAIL busy_write_lo: got %h required 0000000c", lo); end
        wait_done("b2b", cyc);
        checks++;
        if (lo !== 32'd25) begin failures++; $display("FAIL b2b_lo: got %h required 00000019", lo); end
        tick();
    endtask

    task automatic test_cancel();
        int seen_done;
        int cyc;
        wrhi = 1'b1; wrlo = 1'b1; wrdata = 32'h0000_1234;
        tick();
        wrhi = 1'b0; wrdata = 32'h0000_5678;
        tick();
        wrlo = 1'b0;
        checks += 2;
        if (hi !== 32'h1234) begin failures++; $display("FAIL mthi: got %h required 00001234", hi); end
        if (lo !== 32'h5678) begin failures++; $display("FAIL mtlo: got %h required 00005678", lo); end
        launch(2'b10, 32'd100, 32'd7);
        for (int i = 0; i < 13; i++) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL cancel_busy: got %b required 0", busy); end
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) seen_done++;
            tick();
        end
        checks += 3;
        if (seen_done != 0)  begin failures++; $display("FAIL cancel_done: got %0d pulses required 0", seen_done); end
        if (hi !== 32'h1234) begin failures++; $display("FAIL cancel_hi: got %h required 00001234", hi); end
        if (lo !== 32'h5678) begin failures++; $display("FAIL cancel_lo: got %h required 00005678", lo); end
        // Cancel beats a simultaneous Start; a write alongside Start still lands.
        op = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1; cancel = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL cancel_start_busy: got %b required 0", busy); end
        wrlo = 1'b1; wrdata = 32'h0000_AAAA;
        launch(2'b00, 32'd2, 32'd3);
        wrlo = 1'b0;
        checks++;
        if (lo !== 32'hAAAA) begin failures++; $display("FAIL start_write_lo: got %h required 0000aaaa", lo); end
        wait_done("startwrite", cyc);
        checks++;
        if (lo !== 32'd6) begin failures++; $display("FAIL start_write_result: got %h required 00000006", lo); end
        tick();
    endtask

    task automatic test_async_reset();
        int cyc;
        launch(2'b00, 32'd9, 32'd9);
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy: got %b required 0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL areset_done: got %b required 0", done); end
        if (hi !== 32'h0)  begin failures++; $display("FAIL areset_hi: got %h required 0", hi); end
        if (lo !== 32'h0)  begin failures++; $display("FAIL areset_lo: got %h required 0", lo); end
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        launch(2'b00, 32'd6, 32'd7);
        wait_done("after_reset", cyc);
        checks += 2;
        if (lo !== 32'd42) begin failures++; $display("FAIL after_reset_lo: got %h required 0000002a", lo); end
        if (hi !== 32'd0)  begin failures++; $display("FAIL after_reset_hi: got %h required 0", hi); end
    endtask

    initial begin
        test_reset();
        test_multu_latency();
        test_signed();
        test_div_edges();
        test_back_to_back();
        test_cancel();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
